// File: rtl/mul_div_if.sv
// ---------------------------------------------------------------------------
// mul_div_if
//   Handshake and operand/result bundle for the shared multiply/divide engine.
//
//   start    : one-cycle launch request from the control unit
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     : multiplicand/dividend and multiplier/divisor
//   busy     : operation in progress
//   done     : one-cycle completion pulse, hi/lo valid from this cycle on
//   div_zero : accompanies done when a divide had a zero divisor
//   hi, lo   : upper product half / remainder, lower product half / quotient
//
//   master : the control unit side (drives start/op/a/b)
//   slave  : the engine side (drives busy/done/div_zero/hi/lo)
// ---------------------------------------------------------------------------
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide engine producing HI/LO results. One shared
//   2*WIDTH shift register serves both the shift-add multiplier (partial sum
//   in the upper half, multiplier bits in the lower half) and the restoring
//   divider (dividend/quotient in the lower half). Operands are reduced to
//   magnitudes on launch; signs are reapplied in a final FIX cycle.
//
//   Ports:
//     clock_i  : clock, all state updates on the rising edge
//     reset_ni : asynchronous active-low reset
//     bus      : mul_div_if slave modport (start/op/a/b in,
//                busy/done/div_zero/hi/lo out)
//
//   Timing: start sampled at edge E0 in IDLE, WIDTH RUN cycles, one FIX
//   cycle; done/hi/lo are written at E0+WIDTH+1. A divide by zero skips RUN
//   and completes at E0+1.
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clock_i,
    input  logic      reset_ni,
    mul_div_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [CW-1:0]        cnt_q,      cnt_d;
    logic                 is_div_q,   is_div_d;
    logic                 dz_q,       dz_d;
    logic                 neg_res_q,  neg_res_d;
    logic                 neg_rem_q,  neg_rem_d;
    logic [WIDTH-1:0]     a_raw_q,    a_raw_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     opnd_q,     opnd_d;
    // Shared shift register: {partial product, multiplier} or {0, quotient}.
    logic [2*WIDTH-1:0]   acc_q,      acc_d;
    logic [WIDTH-1:0]     rem_q,      rem_d;
    logic                 done_q,     done_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q,       hi_d;
    logic [WIDTH-1:0]     lo_q,       lo_d;

    // ---------------- launch-time operand conditioning ----------------
    logic                 in_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    // op[0] set means unsigned.
    assign in_signed = ~bus.op[0];
    assign a_neg     = in_signed & bus.a[WIDTH-1];
    assign b_neg     = in_signed & bus.b[WIDTH-1];
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    // ---------------- one multiply step ----------------
    logic [WIDTH:0]       mul_sum;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // ---------------- one restoring-divide step ----------------
    // The shifted partial remainder and the trial difference are WIDTH+1
    // bits wide so the borrow of the trial subtraction shows up in the MSB.
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic                 div_neg;

    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_neg   = div_trial[WIDTH];

    // ---------------- sign correction ----------------
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    // Quotient magnitude negated only when operand signs differ gives
    // truncation toward zero; remainder follows the dividend's sign.
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    // ---------------- state register ----------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            a_raw_q    <= a_raw_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // ---------------- next-state and datapath ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        a_raw_d    = a_raw_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        done_d     = 1'b0;      // pulse: only set in FIX
        div_zero_d = 1'b0;      // clears the cycle after done
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    a_raw_d   = bus.a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CW'(WIDTH);
                    rem_d     = '0;
                    if (bus.op[1]) begin
                        opnd_d  = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        dz_d    = (bus.b == '0);
                        state_d = (bus.b == '0) ? S_FIX : S_RUN;
                    end else begin
                        opnd_d  = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        dz_d    = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    rem_d = div_neg ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_neg};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
                if (dz_q) begin
                    hi_d       = a_raw_q;
                    lo_d       = '1;
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed-vector bench for mul_div_unit: a 32-bit and an 8-bit instance,
//   each on its own mul_div_if, sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(32)) bus32 ();
    mul_div_if #(.WIDTH(8))  bus8  ();

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus32)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start strobe; returns just after the sampling edge E0.
    task automatic launch32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
    endtask

    // Count edges until done is seen (bounded) and busy cycles on the way.
    task automatic wait32(output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        while (!bus32.done && lat < 200) begin
            if (bus32.busy) bcyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", 64'(bus32.done), 64'd1);
        check("busy_with_done", 64'(bus32.busy), 64'd0);
    endtask

    task automatic op32(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz, input int exp_lat, input int exp_busy);
        int lat;
        int bcyc;
        launch32(op, a, b);
        wait32(lat, bcyc);
        $display("W32 %s op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h div_zero=%0b latency=%0d busy_cycles=%0d",
                 name, op, a, b, bus32.hi, bus32.lo, bus32.div_zero, lat, bcyc);
        check({name, "_hi"},   64'(bus32.hi),       64'(exp_hi));
        check({name, "_lo"},   64'(bus32.lo),       64'(exp_lo));
        check({name, "_dz"},   64'(bus32.div_zero), 64'(exp_dz));
        check({name, "_lat"},  64'(lat),            64'(exp_lat));
        check({name, "_busy"}, 64'(bcyc),           64'(exp_busy));
    endtask

    task automatic op8(input string name, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_hi, input logic [7:0] exp_lo, input int exp_lat);
        int lat;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("W8 %s op=%0d a=0x%02h b=0x%02h -> hi=0x%02h lo=0x%02h latency=%0d",
                 name, op, a, b, bus8.hi, bus8.lo, lat);
        check({name, "_done"}, 64'(bus8.done), 64'd1);
        check({name, "_hi"},   64'(bus8.hi),   64'(exp_hi));
        check({name, "_lo"},   64'(bus8.lo),   64'(exp_lo));
        check({name, "_lat"},  64'(lat),       64'(exp_lat));
    endtask

    initial begin
        int lat;
        int bcyc;
        int done_cnt;

        bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus32.busy),     64'd0);
        check("rst_done", 64'(bus32.done),     64'd0);
        check("rst_dz",   64'(bus32.div_zero), 64'd0);
        check("rst_hi",   64'(bus32.hi),       64'd0);
        check("rst_lo",   64'(bus32.lo),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // -3 * 7 = -21
        op32("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 33);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus32.done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_lo", 64'(bus32.lo), 64'h0000_0000_FFFF_FFEB);

        // Back-to-back: each op launches in the done cycle of the previous one
        op32("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 33);
        op32("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33);
        op32("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 33);
        // 7 / -2 = -3 rem 1
        op32("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33, 33);
        // 100 / 7 = 14 rem 2
        op32("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33, 33);

        // Divide by zero
        op32("divu_zero", 2'b11, 32'h0000_0064, 32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 1);
        @(posedge clk);
        #1;
        check("dz_clear", 64'(bus32.div_zero), 64'd0);
        check("dz_done_clear", 64'(bus32.done), 64'd0);
        op32("multu_small", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 33);

        // start pulsed mid-RUN with other operands must be ignored
        launch32(2'b00, 32'hFFFF_FFFD, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = 2'b11;
        bus32.a     = 32'd100;
        bus32.b     = 32'd3;
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        wait32(lat, bcyc);
        $display("W32 mid_start -> hi=0x%08h lo=0x%08h remaining_latency=%0d", bus32.hi, bus32.lo, lat);
        check("mid_start_hi",  64'(bus32.hi), 64'h0000_0000_FFFF_FFFF);
        check("mid_start_lo",  64'(bus32.lo), 64'h0000_0000_FFFF_FFEB);
        check("mid_start_lat", 64'(lat),      64'd27);

        // Reset asserted around iteration 10 aborts the operation
        launch32(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus32.busy),     64'd0);
        check("abort_done", 64'(bus32.done),     64'd0);
        check("abort_dz",   64'(bus32.div_zero), 64'd0);
        check("abort_hi",   64'(bus32.hi),       64'd0);
        check("abort_lo",   64'(bus32.lo),       64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus32.done) done_cnt++;
            if (i == 5) rst_n = 1'b1;
        end
        $display("W32 abort -> done pulses after reset=%0d", done_cnt);
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // 8-bit instance: -128 * -128 = 16384
        op8("w8_mult", 2'b00, 8'h80, 8'h80, 8'h40, 8'h00, 9);
        // -127 / 5 = -25 rem -2
        op8("w8_div",  2'b10, 8'h81, 8'h05, 8'hFE, 8'hE7, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
